// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, NOP encoding, ID/EX control bundle
// and the per-instruction field decoder.
package decode_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 8;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_RTYPE = 5'b11011;

    localparam logic [15:0] NOP_ENC = 16'h0800;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       halt;
        logic [2:0] wrReg;
    } idex_ctrl_t;

    typedef struct packed {
        logic        legal;
        logic        reads_rs;
        logic        reads_rt;
        idex_ctrl_t  ctrl;
        logic [15:0] imm;
    } dec_info_t;

    function automatic dec_info_t decode_instr(input logic [15:0] instr);
        dec_info_t d;
        d       = '0;
        d.legal = 1'b1;
        case (instr[15:11])
            OP_HALT: begin
                d.ctrl.halt = 1'b1;
            end
            OP_NOP: begin
                d.legal = 1'b1;
            end
            OP_ADDI: begin
                d.ctrl.regWrite = 1'b1;
                d.ctrl.wrReg    = instr[7:5];
                d.imm           = {{11{instr[4]}}, instr[4:0]};
                d.reads_rs      = 1'b1;
            end
            OP_LD: begin
                d.ctrl.regWrite = 1'b1;
                d.ctrl.memRead  = 1'b1;
                d.ctrl.wrReg    = instr[7:5];
                d.imm           = {{11{instr[4]}}, instr[4:0]};
                d.reads_rs      = 1'b1;
            end
            OP_ST: begin
                d.ctrl.memWrite = 1'b1;
                d.imm           = {{11{instr[4]}}, instr[4:0]};
                d.reads_rs      = 1'b1;
                d.reads_rt      = 1'b1;
            end
            OP_LBI: begin
                d.ctrl.regWrite = 1'b1;
                d.ctrl.wrReg    = instr[10:8];
                d.imm           = {{8{instr[7]}}, instr[7:0]};
            end
            OP_BEQZ: begin
                d.imm      = {{8{instr[7]}}, instr[7:0]};
                d.reads_rs = 1'b1;
            end
            OP_J: begin
                d.imm = {{5{instr[10]}}, instr[10:0]};
            end
            OP_RTYPE: begin
                d.ctrl.regWrite = 1'b1;
                d.ctrl.wrReg    = instr[4:2];
                d.reads_rs      = 1'b1;
                d.reads_rt      = 1'b1;
            end
            default: begin
                d.legal = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8 x 16 register file, combinational reads. With RF_BYPASS_EN defined a same-cycle
// WB write is forwarded to the read ports; otherwise reads see the pre-write value.
module regfile8x16
    import decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       wr_addr,
    input  logic [REG_W-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    input  logic [2:0]       rd_addr_b,
    output logic [REG_W-1:0] rd_data_a,
    output logic [REG_W-1:0] rd_data_b
);

    logic [REG_W-1:0] mem_q [NUM_REGS];
    logic [REG_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= rst ? '0 : mem_d[i];
        end
    end

`ifdef RF_BYPASS_EN
    assign rd_data_a = (we && wr_addr == rd_addr_a) ? wr_data : mem_q[rd_addr_a];
    assign rd_data_b = (we && wr_addr == rd_addr_b) ? wr_data : mem_q[rd_addr_b];
`else
    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
`endif

endmodule

// File: rtl/decode.sv
// Instruction-decode stage: register file, immediate/control decode, load-use hazard
// unit and the ID/EX register. Optional macro RF_BYPASS_EN selects WB->read forwarding.
module decode
    import decode_pkg::*;
#(
    parameter int          LU_STALL  = 1,
    parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_IFID,
    input  logic [15:0] PC_IFID,
    input  logic [15:0] PC2_IFID,
    input  logic        halt_IFID,
    input  logic        freeze,
    input  logic        takeBranch_EXMEM,
    input  logic        wbEn,
    input  logic [2:0]  wbReg,
    input  logic [15:0] wbData,
    output logic        stallCtrl,
    output logic        startStall,
    output logic [15:0] instr_IDEX,
    output logic [15:0] PC_IDEX,
    output logic [15:0] PC2_IDEX,
    output logic [15:0] rsData_IDEX,
    output logic [15:0] rtData_IDEX,
    output logic [15:0] imm_IDEX,
    output logic [2:0]  wrReg_IDEX,
    output logic        regWrite_IDEX,
    output logic        memRead_IDEX,
    output logic        memWrite_IDEX,
    output logic        halt_IDEX,
    output logic        err
);

    logic [2:0]  rs_idx;
    logic [2:0]  rt_idx;
    logic [15:0] rs_rd;
    logic [15:0] rt_rd;
    dec_info_t   dec;

    logic        flush;
    logic        lu_hazard;
    logic        wb_hazard;
    logic        hazard;
    logic        cnt_idle;
    logic        bubble;

    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc2_q, pc2_d;
    logic [15:0] rs_data_q, rs_data_d;
    logic [15:0] rt_data_q, rt_data_d;
    logic [15:0] imm_q, imm_d;
    idex_ctrl_t  ctrl_q, ctrl_d;

    assign rs_idx = instr_IFID[10:8];
    assign rt_idx = instr_IFID[7:5];

    regfile8x16 u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (wbEn),
        .wr_addr   (wbReg),
        .wr_data   (wbData),
        .rd_addr_a (rs_idx),
        .rd_addr_b (rt_idx),
        .rd_data_a (rs_rd),
        .rd_data_b (rt_rd)
    );

    always_comb begin
        dec = decode_instr(instr_IFID);
    end

    // Hazard unit; a flush squashes the consumer, so it overrides any stall request.
    always_comb begin
        flush     = takeBranch_EXMEM & freeze;
        lu_hazard = ctrl_q.memRead &
                    ((ctrl_q.wrReg == rs_idx && dec.reads_rs) ||
                     (ctrl_q.wrReg == rt_idx && dec.reads_rt));
`ifdef RF_BYPASS_EN
        wb_hazard = 1'b0;
`else
        wb_hazard = wbEn &
                    ((wbReg == rs_idx && dec.reads_rs) ||
                     (wbReg == rt_idx && dec.reads_rt));
`endif
        hazard     = lu_hazard | wb_hazard;
        cnt_idle   = (cnt_q == 2'd0);
        startStall = hazard & cnt_idle & ~flush;
        stallCtrl  = ((hazard & cnt_idle) | (cnt_q > 2'd1)) & ~flush;
        bubble     = stallCtrl | flush;
        err        = ~dec.legal & ~flush;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (freeze) begin
            if (flush) begin
                cnt_d = 2'd0;
            end else if (lu_hazard && cnt_idle) begin
                cnt_d = 2'(LU_STALL);
            end else if (!cnt_idle) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc2_d     = pc2_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        if (freeze) begin
            instr_d     = dec.legal ? instr_IFID : NOP_INSTR;
            pc_d        = PC_IFID;
            pc2_d       = PC2_IFID;
            rs_data_d   = rs_rd;
            rt_data_d   = rt_rd;
            imm_d       = dec.imm;
            ctrl_d      = dec.ctrl;
            ctrl_d.halt = dec.ctrl.halt | halt_IFID;
            if (bubble) begin
                instr_d = NOP_INSTR;
                ctrl_d  = '0;
            end
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 2'd0;
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pc2_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc2_q     <= pc2_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign instr_IDEX    = instr_q;
    assign PC_IDEX       = pc_q;
    assign PC2_IDEX      = pc2_q;
    assign rsData_IDEX   = rs_data_q;
    assign rtData_IDEX   = rt_data_q;
    assign imm_IDEX      = imm_q;
    assign wrReg_IDEX    = ctrl_q.wrReg;
    assign regWrite_IDEX = ctrl_q.regWrite;
    assign memRead_IDEX  = ctrl_q.memRead;
    assign memWrite_IDEX = ctrl_q.memWrite;
    assign halt_IDEX     = ctrl_q.halt;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: directed IF/ID vectors push per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_decode;

    localparam int LU = 2;
    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [15:0] T   = 16'd1;
    localparam logic [15:0] F   = 16'd0;

    localparam int S_INSTR = 0;
    localparam int S_PC    = 1;
    localparam int S_PC2   = 2;
    localparam int S_RS    = 3;
    localparam int S_RT    = 4;
    localparam int S_IMM   = 5;
    localparam int S_WR    = 6;
    localparam int S_RW    = 7;
    localparam int S_MR    = 8;
    localparam int S_MW    = 9;
    localparam int S_HALT  = 10;
    localparam int S_STALL = 11;
    localparam int S_START = 12;
    localparam int S_ERR   = 13;
    localparam int S_CNT   = 14;

    logic        clk;
    logic        rst;
    logic [15:0] instr_IFID, PC_IFID, PC2_IFID;
    logic        halt_IFID, freeze, takeBranch_EXMEM, wbEn;
    logic [2:0]  wbReg;
    logic [15:0] wbData;
    logic        stallCtrl, startStall, err;
    logic [15:0] instr_IDEX, PC_IDEX, PC2_IDEX, rsData_IDEX, rtData_IDEX, imm_IDEX;
    logic [2:0]  wrReg_IDEX;
    logic        regWrite_IDEX, memRead_IDEX, memWrite_IDEX, halt_IDEX;

    decode #(.LU_STALL(LU), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_IFID       (instr_IFID),
        .PC_IFID          (PC_IFID),
        .PC2_IFID         (PC2_IFID),
        .halt_IFID        (halt_IFID),
        .freeze           (freeze),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .wbEn             (wbEn),
        .wbReg            (wbReg),
        .wbData           (wbData),
        .stallCtrl        (stallCtrl),
        .startStall       (startStall),
        .instr_IDEX       (instr_IDEX),
        .PC_IDEX          (PC_IDEX),
        .PC2_IDEX         (PC2_IDEX),
        .rsData_IDEX      (rsData_IDEX),
        .rtData_IDEX      (rtData_IDEX),
        .imm_IDEX         (imm_IDEX),
        .wrReg_IDEX       (wrReg_IDEX),
        .regWrite_IDEX    (regWrite_IDEX),
        .memRead_IDEX     (memRead_IDEX),
        .memWrite_IDEX    (memWrite_IDEX),
        .halt_IDEX        (halt_IDEX),
        .err              (err)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
    } ent_t;

    ent_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sample(input int sel);
        case (sel)
            S_INSTR: return instr_IDEX;
            S_PC:    return PC_IDEX;
            S_PC2:   return PC2_IDEX;
            S_RS:    return rsData_IDEX;
            S_RT:    return rtData_IDEX;
            S_IMM:   return imm_IDEX;
            S_WR:    return {13'd0, wrReg_IDEX};
            S_RW:    return {15'd0, regWrite_IDEX};
            S_MR:    return {15'd0, memRead_IDEX};
            S_MW:    return {15'd0, memWrite_IDEX};
            S_HALT:  return {15'd0, halt_IDEX};
            S_STALL: return {15'd0, stallCtrl};
            S_START: return {15'd0, startStall};
            S_ERR:   return {15'd0, err};
            S_CNT:   return {14'd0, dut.cnt_q};
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            S_INSTR: return "instr_IDEX";
            S_PC:    return "PC_IDEX";
            S_PC2:   return "PC2_IDEX";
            S_RS:    return "rsData_IDEX";
            S_RT:    return "rtData_IDEX";
            S_IMM:   return "imm_IDEX";
            S_WR:    return "wrReg_IDEX";
            S_RW:    return "regWrite_IDEX";
            S_MR:    return "memRead_IDEX";
            S_MW:    return "memWrite_IDEX";
            S_HALT:  return "halt_IDEX";
            S_STALL: return "stallCtrl";
            S_START: return "startStall";
            S_ERR:   return "err";
            S_CNT:   return "cnt";
            default: return "unknown";
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        ent_t        e;
        logic [15:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.sel);
            n_tests++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d (checked at %0d): got %h, expected %h",
                         sname(e.sel), e.cyc, cyc, act, e.exp);
            end
        end
    end

    task automatic chk(input int dc, input int sel, input logic [15:0] v);
        ent_t e;
        e.cyc = cyc + dc;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] pc);
        instr_IFID = ins;
        PC_IFID    = pc;
        PC2_IFID   = pc + 16'd2;
    endtask

    // R-type DA70 (reads R2, R3; writes R4) behind an LD R2 sitting in ID/EX.
    task automatic load_use(input logic [15:0] pc);
        drive(16'hDA70, pc);
        chk(0, S_STALL, T);
        chk(0, S_START, T);
        chk(1, S_INSTR, NOP);
        chk(1, S_MR, F);
        chk(1, S_RW, F);
        chk(1, S_CNT, 16'(LU));
        step();
        for (int k = LU; k >= 1; k--) begin
            chk(0, S_STALL, 16'(k > 1));
            chk(0, S_START, F);
            chk(0, S_CNT, 16'(k));
            if (k > 1) begin
                chk(1, S_INSTR, NOP);
            end else begin
                chk(1, S_INSTR, 16'hDA70);
                chk(1, S_RW, T);
                chk(1, S_WR, 16'd4);
                chk(1, S_RT, 16'h1234);
                chk(1, S_PC, pc);
            end
            chk(1, S_CNT, 16'(k - 1));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(NOP, 16'h0000);
        halt_IFID = 1'b0;
        freeze = 1'b1;
        takeBranch_EXMEM = 1'b0;
        wbEn = 1'b0;
        wbReg = 3'd0;
        wbData = 16'h0000;
        step();
        step();
        rst = 1'b0;
        chk(0, S_INSTR, NOP);
        chk(0, S_PC, F);
        chk(0, S_RS, F);
        chk(0, S_IMM, F);
        chk(0, S_WR, F);
        chk(0, S_RW, F);
        chk(0, S_MR, F);
        chk(0, S_MW, F);
        chk(0, S_HALT, F);
        chk(0, S_STALL, F);
        chk(0, S_START, F);
        chk(0, S_CNT, F);

        // Write R3, then ADDI reading R3.
        wbEn = 1'b1; wbReg = 3'd3; wbData = 16'h1234;
        step();
        wbEn = 1'b0;
        drive(16'h4360, 16'h0010);
        chk(0, S_STALL, F);
        chk(0, S_ERR, F);
        chk(1, S_INSTR, 16'h4360);
        chk(1, S_RS, 16'h1234);
        chk(1, S_IMM, 16'h0000);
        chk(1, S_RW, T);
        chk(1, S_WR, 16'd3);
        chk(1, S_PC, 16'h0010);
        chk(1, S_PC2, 16'h0012);
        step();

        // Load-use hazard.
        drive(16'h8840, 16'h0012);
        chk(1, S_INSTR, 16'h8840);
        chk(1, S_MR, T);
        chk(1, S_WR, 16'd2);
        step();
        load_use(16'h0014);

        // Hazard and flush together.
        drive(16'h8840, 16'h0020);
        chk(1, S_MR, T);
        step();
        drive(16'hDA70, 16'h0022);
        takeBranch_EXMEM = 1'b1;
        halt_IFID = 1'b1;
        chk(0, S_STALL, F);
        chk(0, S_ERR, F);
        chk(1, S_INSTR, NOP);
        chk(1, S_MR, F);
        chk(1, S_RW, F);
        chk(1, S_HALT, F);
        chk(1, S_CNT, F);
        step();
        takeBranch_EXMEM = 1'b0;
        halt_IFID = 1'b0;

        // Freeze across a load-use stall.
        drive(16'h8840, 16'h0030);
        chk(1, S_INSTR, 16'h8840);
        chk(1, S_MR, T);
        step();
        freeze = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'hDA70, (i == 0) ? 16'h0032 : 16'hAAAA);
            chk(0, S_STALL, T);
            chk(0, S_START, T);
            chk(1, S_INSTR, 16'h8840);
            chk(1, S_MR, T);
            chk(1, S_PC, 16'h0030);
            chk(1, S_CNT, F);
            step();
        end
        freeze = 1'b1;
        load_use(16'h0032);

        // Illegal opcode, then illegal under flush.
        drive(16'hF800, 16'h0040);
        chk(0, S_ERR, T);
        chk(1, S_INSTR, NOP);
        chk(1, S_RW, F);
        chk(1, S_HALT, F);
        step();
        takeBranch_EXMEM = 1'b1;
        chk(0, S_ERR, F);
        chk(1, S_INSTR, NOP);
        step();
        takeBranch_EXMEM = 1'b0;

        // HALT opcode, then halt flag from fetch.
        drive(16'h0000, 16'h0050);
        chk(0, S_ERR, F);
        chk(1, S_HALT, T);
        chk(1, S_INSTR, 16'h0000);
        chk(1, S_RW, F);
        step();
        drive(NOP, 16'h0052);
        halt_IFID = 1'b1;
        chk(1, S_HALT, T);
        chk(1, S_INSTR, NOP);
        step();
        halt_IFID = 1'b0;

        // Immediate formats.
        drive(16'hC180, 16'h0060);
        chk(1, S_IMM, 16'hFF80);
        chk(1, S_WR, 16'd1);
        chk(1, S_RW, T);
        step();
        drive(16'h2400, 16'h0062);
        chk(1, S_IMM, 16'hFC00);
        chk(1, S_RW, F);
        chk(1, S_WR, F);
        step();
        drive(16'h801F, 16'h0064);
        chk(1, S_IMM, 16'hFFFF);
        chk(1, S_MW, T);
        chk(1, S_MR, F);
        chk(1, S_RW, F);
        step();
        drive(16'h637F, 16'h0066);
        chk(1, S_IMM, 16'h007F);
        chk(1, S_RS, 16'h1234);
        chk(1, S_MW, F);
        step();

        // Same-cycle WB to R5 and a read of R5.
        wbEn = 1'b1; wbReg = 3'd5; wbData = 16'hBEEF;
        drive(16'h4523, 16'h0070);
`ifdef RF_BYPASS_EN
        chk(0, S_STALL, F);
        chk(0, S_START, F);
        chk(1, S_RS, 16'hBEEF);
        chk(1, S_INSTR, 16'h4523);
        chk(1, S_IMM, 16'h0003);
        chk(1, S_CNT, F);
        step();
        wbEn = 1'b0;
`else
        chk(0, S_STALL, T);
        chk(0, S_START, T);
        chk(1, S_INSTR, NOP);
        chk(1, S_RW, F);
        chk(1, S_CNT, F);
        step();
        wbEn = 1'b0;
        chk(0, S_STALL, F);
        chk(1, S_RS, 16'hBEEF);
        chk(1, S_INSTR, 16'h4523);
        chk(1, S_IMM, 16'h0003);
        chk(1, S_WR, 16'd1);
        step();
`endif

        drive(NOP, 16'h0080);
        repeat (3) step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
